// File: rtl/video_tpg_multi_if.sv
// AXI4-Stream video bus from the test-pattern generator to its sink.
// The master drives pixel data and sideband signals; the slave returns tready.
interface video_tpg_multi_if #(
    parameter int DATAW = 32
);
    logic [DATAW-1:0]   tdata;
    logic               tvalid;
    logic               tready;
    logic               tuser;
    logic               tlast;
    logic [DATAW/8-1:0] tkeep;
    logic [DATAW/8-1:0] tstrb;

    modport master (
        output tdata, tvalid, tuser, tlast, tkeep, tstrb,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tuser, tlast, tkeep, tstrb,
        output tready
    );
endinterface

// File: rtl/video_tpg_multi.sv
// Parametrised AXI4-Stream video test-pattern generator: six patterns, stall-safe
// registered outputs, mode latched at frame start and graceful stop at end of frame.
module video_tpg_multi #(
    parameter int DATAW    = 32,
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int CNTW     = 12,
    parameter int CHK_LOG2 = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [2:0]          mode,
    input  logic [23:0]         solid_color,
    video_tpg_multi_if.master   m_axis,
    output logic                frame_done,
    output logic [15:0]         frame_cnt
);

    localparam logic [CNTW-1:0] X_LAST   = CNTW'(H_ACTIVE - 1);
    localparam logic [CNTW-1:0] Y_LAST   = CNTW'(V_ACTIVE - 1);
    localparam logic [CNTW-1:0] X_HALF   = CNTW'(H_ACTIVE / 2);
    localparam logic [CNTW-1:0] Y_HALF   = CNTW'(V_ACTIVE / 2);
    localparam logic [CNTW-1:0] BAR_LAST = CNTW'(H_ACTIVE / 8 - 1);
    localparam logic [CNTW:0]   H_WIDE   = (CNTW+1)'(H_ACTIVE);
    localparam logic [CNTW:0]   BAR_STEP = (CNTW+1)'(8);
    localparam logic [CNTW:0]   BAR_SPAN = (CNTW+1)'(32);

    localparam logic [23:0] WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BLACK   = 24'h000000;
    localparam logic [23:0] GREEN   = 24'h0000FF;
    localparam logic [23:0] RED     = 24'h00FF00;
    localparam logic [23:0] BLUE    = 24'hFF0000;
    localparam logic [23:0] CYAN    = 24'hFF00FF;
    localparam logic [23:0] YELLOW  = 24'h00FFFF;
    localparam logic [23:0] MAGENTA = 24'hFFFF00;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t          state_reg;
    logic [CNTW-1:0] x_reg;
    logic [CNTW-1:0] y_reg;
    logic [2:0]      bar_idx_reg;
    logic [CNTW-1:0] bar_sub_reg;
    logic [CNTW-1:0] bar_pos_reg;
    logic [2:0]      mode_reg;
    logic [23:0]     color_reg;
    logic [23:0]     tdata_reg;
    logic            tvalid_reg;
    logic            tuser_reg;
    logic            tlast_reg;
    logic            frame_done_reg;
    logic [15:0]     frame_cnt_reg;

    logic [CNTW-1:0] x_next;
    logic [CNTW-1:0] y_next;
    logic [2:0]      bar_idx_next;
    logic [CNTW-1:0] bar_sub_next;
    logic [CNTW-1:0] bar_pos_next;
    logic [CNTW:0]   bar_pos_sum;
    logic [CNTW-1:0] first_bar_pos;
    logic            last_col;
    logic            frame_last;
    logic            xfer;
    logic [23:0]     pix_next;
    logic [23:0]     pix_first;

    function automatic logic [23:0] bar_color(input logic [2:0] bi);
        case (bi)
            3'd0:    bar_color = WHITE;
            3'd1:    bar_color = YELLOW;
            3'd2:    bar_color = CYAN;
            3'd3:    bar_color = GREEN;
            3'd4:    bar_color = MAGENTA;
            3'd5:    bar_color = RED;
            3'd6:    bar_color = BLUE;
            default: bar_color = BLACK;
        endcase
    endfunction

    function automatic logic [23:0] pattern(
        input logic [2:0]      m,
        input logic [23:0]     c,
        input logic [CNTW-1:0] px,
        input logic [CNTW-1:0] py,
        input logic [2:0]      bi,
        input logic [CNTW-1:0] bp
    );
        logic [CNTW:0] px_w;
        logic [CNTW:0] bp_w;
        px_w = {1'b0, px};
        bp_w = {1'b0, bp};
        case (m)
            3'd0: pattern = c;
            3'd1: begin
                if (py < Y_HALF)      pattern = GREEN;
                else if (px < X_HALF) pattern = RED;
                else                  pattern = BLUE;
            end
            3'd2:    pattern = bar_color(bi);
            3'd3:    pattern = (px[CHK_LOG2] ^ py[CHK_LOG2]) ? WHITE : BLACK;
            3'd4:    pattern = {3{8'(px)}};
            // The bar clips naturally: px never exceeds H_ACTIVE-1.
            3'd5:    pattern = (px_w >= bp_w && px_w < bp_w + BAR_SPAN) ? WHITE : BLACK;
            default: pattern = BLACK;
        endcase
    endfunction

    always_comb begin
        last_col   = (x_reg == X_LAST);
        frame_last = last_col && (y_reg == Y_LAST);
        xfer       = tvalid_reg & m_axis.tready;

        x_next = last_col ? '0 : x_reg + CNTW'(1);
        if (last_col) y_next = (y_reg == Y_LAST) ? '0 : y_reg + CNTW'(1);
        else          y_next = y_reg;

        // Bar index tracks x through a sub-counter so no divider is needed.
        if (last_col) begin
            bar_idx_next = 3'd0;
            bar_sub_next = '0;
        end else if (bar_sub_reg == BAR_LAST) begin
            bar_idx_next = bar_idx_reg + 3'd1;
            bar_sub_next = '0;
        end else begin
            bar_idx_next = bar_idx_reg;
            bar_sub_next = bar_sub_reg + CNTW'(1);
        end

        bar_pos_sum  = {1'b0, bar_pos_reg} + BAR_STEP;
        bar_pos_next = (bar_pos_sum >= H_WIDE) ? '0 : bar_pos_sum[CNTW-1:0];

        // A frame started back-to-back already sees the advanced bar position.
        first_bar_pos = (state_reg == IDLE) ? bar_pos_reg : bar_pos_next;

        pix_next  = pattern(mode_reg, color_reg, x_next, y_next, bar_idx_next, bar_pos_reg);
        pix_first = pattern(mode, solid_color, '0, '0, 3'd0, first_bar_pos);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            x_reg          <= '0;
            y_reg          <= '0;
            bar_idx_reg    <= 3'd0;
            bar_sub_reg    <= '0;
            bar_pos_reg    <= '0;
            mode_reg       <= 3'd0;
            color_reg      <= 24'd0;
            tdata_reg      <= 24'd0;
            tvalid_reg     <= 1'b0;
            tuser_reg      <= 1'b0;
            tlast_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_cnt_reg  <= 16'd0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        mode_reg    <= mode;
                        color_reg   <= solid_color;
                        tdata_reg   <= pix_first;
                        tvalid_reg  <= 1'b1;
                        tuser_reg   <= 1'b1;
                        tlast_reg   <= 1'b0;
                        x_reg       <= '0;
                        y_reg       <= '0;
                        bar_idx_reg <= 3'd0;
                        bar_sub_reg <= '0;
                        state_reg   <= RUN;
                    end
                end
                RUN, STOPPING: begin
                    if (xfer && frame_last) begin
                        frame_done_reg <= 1'b1;
                        frame_cnt_reg  <= frame_cnt_reg + 16'd1;
                        bar_pos_reg    <= bar_pos_next;
                        x_reg          <= '0;
                        y_reg          <= '0;
                        bar_idx_reg    <= 3'd0;
                        bar_sub_reg    <= '0;
                        tlast_reg      <= 1'b0;
                        if (state_reg == RUN && en) begin
                            mode_reg  <= mode;
                            color_reg <= solid_color;
                            tdata_reg <= pix_first;
                            tuser_reg <= 1'b1;
                        end else begin
                            tvalid_reg <= 1'b0;
                            tuser_reg  <= 1'b0;
                            state_reg  <= IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            x_reg       <= x_next;
                            y_reg       <= y_next;
                            bar_idx_reg <= bar_idx_next;
                            bar_sub_reg <= bar_sub_next;
                            tdata_reg   <= pix_next;
                            tuser_reg   <= 1'b0;
                            tlast_reg   <= (x_next == X_LAST);
                        end
                        if (state_reg == RUN && !en) state_reg <= STOPPING;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign m_axis.tdata[23:0] = tdata_reg;
    assign m_axis.tvalid      = tvalid_reg;
    assign m_axis.tuser       = tuser_reg;
    assign m_axis.tlast       = tlast_reg;
    assign frame_done         = frame_done_reg;
    assign frame_cnt          = frame_cnt_reg;

    generate
        if (DATAW > 24) begin : g_pad
            assign m_axis.tdata[DATAW-1:24] = '0;
        end
        for (genvar gi = 0; gi < DATAW/8; gi++) begin : g_byte
            assign m_axis.tkeep[gi] = 1'b1;
            assign m_axis.tstrb[gi] = 1'b1;
        end
    endgenerate

endmodule
